// File: rtl/bert_prbs_checker.sv
// PRBS-7/15/23/31 receive checker for one BERT lane: self-seeding LFSR, lock FSM, saturating BER counters.
// Optional ILA error-position port enabled by defining BERT_ERRMASK_OUTPUT_EN.
module bert_prbs_checker #(
    parameter int WIDTH       = 32,
    parameter int LOCK_WORDS  = 16,
    parameter int WINDOW      = 256,
    parameter int LOSS_THRESH = 64,
    parameter int CNT_WIDTH   = 48
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2:0]           prbs_sel,
    input  logic                 rx_invert,
    input  logic                 rx_valid,
    input  logic [WIDTH-1:0]     rx_data,
    input  logic                 clear,
    output logic                 locked,
    output logic                 lock_lost,
    output logic [CNT_WIDTH-1:0] bit_count,
    output logic [CNT_WIDTH-1:0] err_count,
    output logic                 word_err
`ifdef BERT_ERRMASK_OUTPUT_EN
    ,
    output logic [WIDTH-1:0]     err_mask
`endif
);

    localparam int POP_W  = $clog2(WIDTH + 1);
    localparam int LOCK_W = $clog2(LOCK_WORDS + 1);
    localparam int WIN_W  = $clog2(WINDOW + 1);
    localparam int ACC_W  = $clog2(LOSS_THRESH + WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SEED, VERIFY, LOCKED} state_t;

    state_t                 state_q, state_d;
    logic [30:0]            hist_q, hist_d;
    logic [2:0]             sel_q;
    logic                   inv_q;
    logic [LOCK_W-1:0]      clean_q, clean_d;
    logic [WIN_W-1:0]       win_q, win_d;
    logic [ACC_W-1:0]       acc_q, acc_d, accSum;
    logic [CNT_WIDTH-1:0]   bitCnt_q, bitCnt_d, errCnt_q, errCnt_d;
    logic                   lockLost_q, lockLost_d;
    logic                   s1Valid_q, s1Locked_q, s2Valid_q, s2Locked_q;
    logic [WIDTH-1:0]       errMask_q;
    logic [POP_W-1:0]       pop_q, popNext;
    logic                   wordErr_q;
    logic [WIDTH-1:0]       d, expected, mask;
    logic                   selOn, cfgChange, flush;

    // Bit 31+i of ext is the i-th new bit; hist[30] is the newest history bit.
    function automatic logic [WIDTH-1:0] prbsWord(input logic [30:0] hist, input int tapA, input int tapB);
        logic [WIDTH+30:0] ext;
        ext        = '0;
        ext[30:0]  = hist;
        for (int i = 0; i < WIDTH; i++)
            ext[31+i] = ext[31+i-tapA] ^ ext[31+i-tapB];
        return ext[WIDTH+30:31];
    endfunction

    function automatic logic [CNT_WIDTH-1:0] satAdd(input logic [CNT_WIDTH-1:0] cnt, input logic [POP_W-1:0] inc);
        logic [CNT_WIDTH:0] sum;
        sum = {1'b0, cnt} + (CNT_WIDTH+1)'(inc);
        return sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
    endfunction

    always_comb begin
        d = rx_data ^ {WIDTH{rx_invert}};
        case (prbs_sel)
            3'b001:  expected = prbsWord(hist_q, 7, 6);
            3'b010:  expected = prbsWord(hist_q, 15, 14);
            3'b011:  expected = prbsWord(hist_q, 23, 18);
            3'b100:  expected = prbsWord(hist_q, 31, 28);
            default: expected = '0;
        endcase
        mask      = d ^ expected;
        selOn     = (prbs_sel >= 3'd1) && (prbs_sel <= 3'd4);
        cfgChange = (prbs_sel != sel_q) || (rx_invert != inv_q);
        popNext   = '0;
        for (int i = 0; i < WIDTH; i++)
            popNext = popNext + POP_W'(errMask_q[i]);
    end

    // Lock decisions and counter updates act on stage-2 results; any exit flushes words in flight.
    always_comb begin
        state_d  = state_q;
        hist_d   = hist_q;
        clean_d  = clean_q;
        win_d    = win_q;
        acc_d    = acc_q;
        bitCnt_d = bitCnt_q;
        errCnt_d = errCnt_q;
        flush    = 1'b0;
        accSum   = acc_q + ACC_W'(pop_q);
        if (!selOn || cfgChange) begin
            state_d = selOn ? SEED : IDLE;
            flush   = 1'b1;
            clean_d = '0;
            win_d   = '0;
            acc_d   = '0;
        end else begin
            case (state_q)
                IDLE: state_d = SEED;
                SEED: begin
                    if (rx_valid) begin
                        hist_d  = d[WIDTH-1 -: 31];
                        clean_d = '0;
                        state_d = VERIFY;
                    end
                end
                VERIFY: begin
                    if (rx_valid)
                        hist_d = d[WIDTH-1 -: 31];
                    if (s2Valid_q && !s2Locked_q) begin
                        if (pop_q != '0) begin
                            state_d = SEED;
                            flush   = 1'b1;
                            clean_d = '0;
                        end else if (clean_q == LOCK_W'(LOCK_WORDS - 1)) begin
                            state_d = LOCKED;
                            clean_d = '0;
                            win_d   = '0;
                            acc_d   = '0;
                        end else begin
                            clean_d = clean_q + LOCK_W'(1);
                        end
                    end
                end
                LOCKED: begin
                    // Free-running from predicted bits so received errors never corrupt the reference.
                    if (rx_valid)
                        hist_d = expected[WIDTH-1 -: 31];
                    if (s2Valid_q && s2Locked_q) begin
                        bitCnt_d = satAdd(bitCnt_q, POP_W'(WIDTH));
                        errCnt_d = satAdd(errCnt_q, pop_q);
                        if (accSum >= ACC_W'(LOSS_THRESH)) begin
                            state_d = SEED;
                            flush   = 1'b1;
                            win_d   = '0;
                            acc_d   = '0;
                        end else if (win_q == WIN_W'(WINDOW - 1)) begin
                            win_d = '0;
                            acc_d = '0;
                        end else begin
                            win_d = win_q + WIN_W'(1);
                            acc_d = accSum;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        if (clear) begin
            bitCnt_d = '0;
            errCnt_d = '0;
        end
        lockLost_d = (state_q == LOCKED) && (state_d == SEED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            hist_q     <= '0;
            sel_q      <= '0;
            inv_q      <= 1'b0;
            clean_q    <= '0;
            win_q      <= '0;
            acc_q      <= '0;
            bitCnt_q   <= '0;
            errCnt_q   <= '0;
            lockLost_q <= 1'b0;
            s1Valid_q  <= 1'b0;
            s1Locked_q <= 1'b0;
            errMask_q  <= '0;
            s2Valid_q  <= 1'b0;
            s2Locked_q <= 1'b0;
            pop_q      <= '0;
            wordErr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hist_q     <= hist_d;
            sel_q      <= prbs_sel;
            inv_q      <= rx_invert;
            clean_q    <= clean_d;
            win_q      <= win_d;
            acc_q      <= acc_d;
            bitCnt_q   <= bitCnt_d;
            errCnt_q   <= errCnt_d;
            lockLost_q <= lockLost_d;
            s1Locked_q <= (state_q == LOCKED);
            errMask_q  <= mask;
            s2Locked_q <= s1Locked_q;
            pop_q      <= popNext;
            if (flush) begin
                s1Valid_q <= 1'b0;
                s2Valid_q <= 1'b0;
            end else begin
                s1Valid_q <= rx_valid && ((state_q == VERIFY) || (state_q == LOCKED));
                s2Valid_q <= s1Valid_q;
                if (s1Valid_q)
                    wordErr_q <= |errMask_q;
            end
        end
    end

`ifdef BERT_ERRMASK_OUTPUT_EN
    logic [WIDTH-1:0] errMaskOut_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            errMaskOut_q <= '0;
        else
            errMaskOut_q <= (!flush && rx_valid && ((state_q == VERIFY) || (state_q == LOCKED))) ? mask : '0;
    end

    assign err_mask = errMaskOut_q;
`endif

    assign locked    = (state_q == LOCKED);
    assign lock_lost = lockLost_q;
    assign bit_count = bitCnt_q;
    assign err_count = errCnt_q;
    assign word_err  = wordErr_q;

endmodule
